// File: rtl/arc4_pkg.sv
// Shared RC4 types: PRGA state encoding and the printable-byte window
// used by both prga and crack.
package arc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RDL,
        LEN,
        RDI,
        RDJ,
        WRI,
        WRJ,
        RDP,
        WRP
    } prga_state_t;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

endpackage

// File: rtl/prga.sv
// RC4 keystream generator: decrypts a length-prefixed ciphertext against
// a KSA-filled S-memory and flags non-printable plaintext bytes.
module prga
    import arc4_pkg::*;
#(
    parameter bit         ABORT_ON_BAD = 1'b0,
    parameter logic [7:0] CHK_LO       = PRINT_LO,
    parameter logic [7:0] CHK_HI       = PRINT_HI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren,
    output logic       pt_bad
);

    prga_state_t state, nxt;

    logic [7:0] i, j, k, len;
    logic [7:0] si, sj, ct_byte;
    logic [7:0] pad;
    logic       bad;
    logic       last;

    assign pad  = s_rddata ^ ct_byte;
    assign bad  = (pad < CHK_LO) || (pad > CHK_HI);
    // k is compared before increment so L=255 ends without wrapping
    assign last = (k == len) || (ABORT_ON_BAD && bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = en ? RDL : IDLE;
            RDL:     nxt = LEN;
            LEN:     nxt = (ct_rddata == 8'd0) ? IDLE : RDI;
            RDI:     nxt = RDJ;
            RDJ:     nxt = WRI;
            WRI:     nxt = WRJ;
            WRJ:     nxt = RDP;
            RDP:     nxt = WRP;
            WRP:     nxt = last ? IDLE : RDI;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i       <= 8'd0;
            j       <= 8'd0;
            k       <= 8'd0;
            len     <= 8'd0;
            si      <= 8'd0;
            sj      <= 8'd0;
            ct_byte <= 8'd0;
            pt_bad  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        i      <= 8'd0;
                        j      <= 8'd0;
                        k      <= 8'd0;
                        pt_bad <= 1'b0;
                    end
                end
                LEN: begin
                    len <= ct_rddata;
                    k   <= 8'd1;
                end
                RDI: i <= i + 8'd1;
                RDJ: begin
                    si <= s_rddata;
                    j  <= j + s_rddata;
                end
                WRI: sj <= s_rddata;
                RDP: ct_byte <= ct_rddata;
                WRP: begin
                    if (bad) pt_bad <= 1'b1;
                    if (!last) k <= k + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        unique case (state)
            IDLE: rdy = 1'b1;
            LEN: begin
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
            end
            RDI: s_addr = i + 8'd1;
            RDJ: s_addr = j + s_rddata;
            WRI: begin
                s_addr   = i;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
            end
            WRJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                ct_addr  = k;
            end
            // latched pre-swap si+sj equals post-swap s[i]+s[j]
            RDP: s_addr = si + sj;
            WRP: begin
                pt_addr   = k;
                pt_wrdata = pad;
                pt_wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
